// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit for MULT/MULTU/DIV/DIVU.
//
// A small FSM (IDLE -> PREP -> RUN -> FIXUP -> DONE) sequences a WIDTH-step
// shift-add multiply or restoring divide on operands latched at accept time.
// The 2*WIDTH-bit result lands in the architectural HI/LO registers.
//
// Handshake: the core raises start (with op/operands) and holds it until
// stall drops. A start is accepted only on an edge where the unit is IDLE.
// stall is high from the accept cycle until the result is written. done
// pulses for exactly one cycle when HI/LO become valid. Starts seen while
// busy, including during DONE, are ignored.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, op[1:0]          request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a, operand_b    rs (multiplicand/dividend), rt (multiplier/divisor)
//   busy, done, stall       status to the core
//   hi, lo                  result: upper product/remainder, lower product/quotient
//   div_by_zero             last divide had a zero divisor
//   dbg_state               current FSM state (debug visibility)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [2:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   mcand;      // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0]   mplr;       // multiplier magnitude, consumed LSB first
  logic [2*WIDTH-1:0] acc;        // product, or {rem, quo} for divide
  logic [CW-1:0]      cnt;

  logic               is_div, is_signed, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_q_c, neg_r_c;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = (b_q == '0);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PREP;
      S_PREP:  state_nxt = (is_div && b_zero) ? S_DONE : S_RUN;
      S_RUN:   if (cnt == LAST) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign stall     = ((state == S_IDLE) && start) || (state == S_PREP) ||
                     (state == S_RUN) || (state == S_FIXUP);
  assign dbg_state = state;

  // ---------------- datapath combinational ----------------
  always_comb begin
    mag_a   = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b   = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    neg_q_c = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_r_c = is_signed && a_q[WIDTH-1];

    // Multiply step: add into the upper half (carry kept), then shift right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplr[0] ? mcand : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide step. The bit shifted out of rem is kept as the top
    // of the trial subtraction, since 2*rem can exceed WIDTH bits.
    div_shift = {acc[2*WIDTH-2:0], 1'b0};
    div_diff  = {acc[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} - {1'b0, mcand};
    div_next  = div_diff[WIDTH] ? div_shift
                                : {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};

    fix_prod = neg_q ? -acc : acc;
    fix_quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fix_rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mcand       <= '0;
      mplr        <= '0;
      acc         <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q        <= op;
            a_q         <= operand_a;
            b_q         <= operand_b;
            div_by_zero <= 1'b0;
          end
        end
        S_PREP: begin
          neg_q <= neg_q_c;
          neg_r <= neg_r_c;
          mcand <= is_div ? mag_b : mag_a;
          mplr  <= mag_b;
          // Remainder half starts cleared; a divide seeds the quotient half
          // with the dividend so it shifts into the remainder bit by bit.
          acc   <= is_div ? {{WIDTH{1'b0}}, mag_a} : '0;
          cnt   <= '0;
          if (is_div && b_zero) begin
            hi          <= a_q;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end
        end
        S_RUN: begin
          acc  <= is_div ? div_next : mul_next;
          mplr <= mplr >> 1;
          cnt  <= cnt + CW'(1);
        end
        S_FIXUP: begin
          if (is_div) begin
            hi <= fix_rem;
            lo <= fix_quo;
          end else begin
            hi <= fix_prod[2*WIDTH-1:WIDTH];
            lo <= fix_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
